// File: rtl/rv32i_pkg.sv
// rv32i_pkg: RV32I opcodes, ALU op encoding, immediate formats and ex_ctrl bit layout
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    // FMT_NONE covers opcodes with no immediate and no register reads (FENCE, SYSTEM, illegal)
    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
    } fmt_t;

    // ex_ctrl = {wb_en, mem_rd, mem_wr, branch, jal, jalr, alu_src_imm}
    localparam int CTRL_WB   = 6;
    localparam int CTRL_MRD  = 5;
    localparam int CTRL_MWR  = 4;
    localparam int CTRL_BR   = 3;
    localparam int CTRL_JAL  = 2;
    localparam int CTRL_JALR = 1;
    localparam int CTRL_IMM  = 0;

    // instr[30] picks SUB only for register-register OP; for shifts it picks SRA in both forms
    function automatic alu_op_t alu_dec(input logic [2:0] f3, input logic b30, input logic is_op);
        case (f3)
            3'b000:  return (is_op && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return b30 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate extraction
//   instr in  32  instruction word
//   imm   out 32  sign-extended immediate (0 for R-type and FMT_NONE)
//   fmt   out     instruction format, also used to tell which source registers are read
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output fmt_t        fmt
);

    logic [6:0] opc;

    assign opc = instr[6:0];

    always_comb begin
        fmt = (opc == OPC_LUI || opc == OPC_AUIPC)                      ? FMT_U :
              (opc == OPC_JAL)                                          ? FMT_J :
              (opc == OPC_JALR || opc == OPC_LOAD || opc == OPC_OPIMM)  ? FMT_I :
              (opc == OPC_BRANCH)                                       ? FMT_B :
              (opc == OPC_STORE)                                        ? FMT_S :
              (opc == OPC_OP)                                           ? FMT_R : FMT_NONE;
        imm = (fmt == FMT_I) ? {{20{instr[31]}}, instr[31:20]} :
              (fmt == FMT_S) ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
              (fmt == FMT_B) ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
              (fmt == FMT_U) ? {instr[31:12], 12'd0} :
              (fmt == FMT_J) ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
              32'd0;
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode plus ID/EX pipeline register with load-use bubble and EX flush
//   clk, reset (async, active-low)
//   if_valid/if_instr/if_pc -> id_ready         fetch handshake
//   rf_raddr1/2 -> rf_rdata1/2                  RegFile read (addresses combinational from if_instr)
//   wb_wr_en/wb_addr/wb_data                    writeback port, used for capture bypass
//   ex_flush, ex_ready -> ex_valid, ex_*        ID/EX register towards EX
// Build option: define WB_BYPASS_EN to capture wb_data when writeback hits a source register.
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RF_AW = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic             id_ready,
    output logic [RF_AW-1:0] rf_raddr1,
    output logic [RF_AW-1:0] rf_raddr2,
    input  logic [XLEN-1:0]  rf_rdata1,
    input  logic [XLEN-1:0]  rf_rdata2,
    input  logic             wb_wr_en,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             ex_flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_val,
    output logic [XLEN-1:0]  ex_rs2_val,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_alu_op,
    output logic [2:0]       ex_funct3,
    output logic [6:0]       ex_ctrl,
    output logic             ex_illegal
);

    logic [6:0]      opc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    fmt_t            fmt;
    alu_op_t         alu;
    logic [6:0]      ctrl;
    logic            illegal;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            advance;
    logic            hazard;
    logic            load;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    assign opc = if_instr[6:0];
    assign rs1 = if_instr[19:15];
    assign rs2 = if_instr[24:20];

    assign rf_raddr1 = {{(RF_AW-5){1'b0}}, rs1};
    assign rf_raddr2 = {{(RF_AW-5){1'b0}}, rs2};

    imm_gen u_imm_gen (
        .instr(if_instr),
        .imm  (imm),
        .fmt  (fmt)
    );

    always_comb begin
        alu     = ALU_ADD;
        ctrl    = '0;
        illegal = 1'b0;
        case (opc)
            OPC_LUI: begin
                alu            = ALU_PASSB;
                ctrl[CTRL_WB]  = 1'b1;
                ctrl[CTRL_IMM] = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl[CTRL_WB]  = 1'b1;
                ctrl[CTRL_IMM] = 1'b1;
            end
            OPC_JAL: begin
                ctrl[CTRL_WB]  = 1'b1;
                ctrl[CTRL_JAL] = 1'b1;
                ctrl[CTRL_IMM] = 1'b1;
            end
            OPC_JALR: begin
                ctrl[CTRL_WB]   = 1'b1;
                ctrl[CTRL_JALR] = 1'b1;
                ctrl[CTRL_IMM]  = 1'b1;
            end
            OPC_BRANCH: begin
                alu           = ALU_SUB;
                ctrl[CTRL_BR] = 1'b1;
            end
            OPC_LOAD: begin
                ctrl[CTRL_WB]  = 1'b1;
                ctrl[CTRL_MRD] = 1'b1;
                ctrl[CTRL_IMM] = 1'b1;
            end
            OPC_STORE: begin
                ctrl[CTRL_MWR] = 1'b1;
                ctrl[CTRL_IMM] = 1'b1;
            end
            OPC_OPIMM: begin
                alu            = alu_dec(if_instr[14:12], if_instr[30], 1'b0);
                ctrl[CTRL_WB]  = 1'b1;
                ctrl[CTRL_IMM] = 1'b1;
            end
            OPC_OP: begin
                alu           = alu_dec(if_instr[14:12], if_instr[30], 1'b1);
                ctrl[CTRL_WB] = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: ;
            default: illegal = 1'b1;
        endcase
    end

    assign rd = ctrl[CTRL_WB] ? if_instr[11:7] : 5'd0;

    assign uses_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
    assign uses_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);

    assign advance  = !ex_valid || ex_ready;
    assign hazard   = ex_valid && ex_ctrl[CTRL_MRD] && (ex_rd != 5'd0) &&
                      ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));
    assign id_ready = advance && !hazard && !ex_flush;
    assign load     = if_valid && id_ready;

`ifdef WB_BYPASS_EN
    logic byp1;
    logic byp2;

    assign byp1 = wb_wr_en && (wb_addr != 5'd0) && (wb_addr == rs1);
    assign byp2 = wb_wr_en && (wb_addr != 5'd0) && (wb_addr == rs2);
    assign op1  = (rs1 == 5'd0) ? '0 : byp1 ? wb_data : rf_rdata1;
    assign op2  = (rs2 == 5'd0) ? '0 : byp2 ? wb_data : rf_rdata2;
`else
    logic unused_wb;

    assign unused_wb = ^{wb_wr_en, wb_addr, wb_data};
    assign op1       = (rs1 == 5'd0) ? '0 : rf_rdata1;
    assign op2       = (rs2 == 5'd0) ? '0 : rf_rdata2;
`endif

    // flush and bubble both fall out of load=0 because id_ready already excludes them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_rs1_val <= '0;
            ex_rs2_val <= '0;
            ex_imm     <= '0;
            ex_rd      <= '0;
            ex_alu_op  <= '0;
            ex_funct3  <= '0;
            ex_ctrl    <= '0;
            ex_illegal <= 1'b0;
        end else begin
            if (ex_flush || advance)
                ex_valid <= load;
            if (load) begin
                ex_pc      <= if_pc;
                ex_rs1_val <= op1;
                ex_rs2_val <= op2;
                ex_imm     <= imm;
                ex_rd      <= rd;
                ex_alu_op  <= alu;
                ex_funct3  <= if_instr[14:12];
                ex_ctrl    <= ctrl;
                ex_illegal <= illegal;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [6:0]  ctrl;
        logic        ill;
    } exp_t;

    localparam logic [6:0] C_WB  = 7'b1000000;
    localparam logic [6:0] C_MRD = 7'b0100000;
    localparam logic [6:0] C_BR  = 7'b0001000;
    localparam logic [6:0] C_IMM = 7'b0000001;

`ifdef WB_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'd30;
`else
    localparam logic [31:0] BYP_EXP = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;
    logic [31:0] if_pc = '0;
    logic        id_ready;
    logic [31:0] rf_raddr1;
    logic [31:0] rf_raddr2;
    logic [31:0] rf_rdata1 = '0;
    logic [31:0] rf_rdata2 = '0;
    logic        wb_wr_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        ex_flush = 1'b0;
    logic        ex_ready = 1'b1;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_alu_op;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_ctrl;
    logic        ex_illegal;

    int   total = 0;
    int   bad = 0;
    exp_t nxt;
    exp_t obs;
    exp_t q[$];

    decode_stage dut (
        .clk       (clk),
        .reset     (reset),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .id_ready  (id_ready),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .wb_wr_en  (wb_wr_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .ex_flush  (ex_flush),
        .ex_ready  (ex_ready),
        .ex_valid  (ex_valid),
        .ex_pc     (ex_pc),
        .ex_rs1_val(ex_rs1_val),
        .ex_rs2_val(ex_rs2_val),
        .ex_imm    (ex_imm),
        .ex_rd     (ex_rd),
        .ex_alu_op (ex_alu_op),
        .ex_funct3 (ex_funct3),
        .ex_ctrl   (ex_ctrl),
        .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    assign obs = {ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_alu_op, ex_funct3, ex_ctrl, ex_illegal};

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] e1, input logic [31:0] e2,
                         input logic [31:0] imm, input logic [4:0] rd, input logic [3:0] alu,
                         input logic [6:0] ctrl, input logic ill);
        if_valid  = 1'b1;
        if_instr  = ins;
        if_pc     = pc;
        rf_rdata1 = d1;
        rf_rdata2 = d2;
        nxt       = {pc, e1, e2, imm, rd, alu, ins[14:12], ctrl, ill};
    endtask

    task automatic cyc(input logic erdy, input string tag);
        @(negedge clk);
        total++;
        assert (id_ready === erdy) else begin
            bad++;
            $error("FAIL %s id_ready got=%0b exp=%0b", tag, id_ready, erdy);
        end
        total++;
        assert (ex_valid === (q.size() != 0)) else begin
            bad++;
            $error("FAIL %s ex_valid got=%0b exp=%0b", tag, ex_valid, q.size() != 0);
        end
        if (ex_valid && q.size() != 0) begin
            total++;
            assert (obs === q[0]) else begin
                bad++;
                $error("FAIL %s idex got=%h exp=%h", tag, obs, q[0]);
            end
            if (ex_ready)
                void'(q.pop_front());
        end
        if (ex_flush)
            q.delete();
        if (if_valid && erdy)
            q.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        total++;
        assert (obs === '0 && ex_valid === 1'b0) else begin
            bad++;
            $error("FAIL reset_state got=%h/%0b exp=0", obs, ex_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        drive(32'h01400093, 32'h100, 32'hDEAD, 32'h55, 32'h0, 32'h55, 32'd20, 5'd1, 4'd0, C_WB | C_IMM, 1'b0);
        cyc(1'b1, "addi_pos");
        drive(32'hFFF00293, 32'h104, 32'h1234, 32'h77, 32'h0, 32'h77, 32'hFFFFFFFF, 5'd5, 4'd0, C_WB | C_IMM, 1'b0);
        cyc(1'b1, "addi_neg");
        drive(32'hFE000EE3, 32'h108, 32'h9, 32'h8, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd0, 4'd1, C_BR, 1'b0);
        cyc(1'b1, "beq");
        drive(32'h0000A103, 32'h10C, 32'h1000, 32'h3, 32'h1000, 32'h0, 32'h0, 5'd2, 4'd0, C_WB | C_MRD | C_IMM, 1'b0);
        cyc(1'b1, "lw");
        drive(32'h001101B3, 32'h110, 32'h22, 32'h11, 32'h22, 32'h11, 32'h0, 5'd3, 4'd0, C_WB, 1'b0);
        cyc(1'b0, "load_use");
        cyc(1'b1, "after_bubble");

        ex_ready = 1'b0;
        drive(32'h40208233, 32'h114, 32'hAAAA, 32'hBBBB, 32'hAAAA, 32'hBBBB, 32'h0, 5'd4, 4'd1, C_WB, 1'b0);
        repeat (3) cyc(1'b0, "stall");
        ex_ready = 1'b1;
        cyc(1'b1, "release");

        drive(32'h123453B7, 32'h118, 32'h1, 32'h2, 32'h1, 32'h2, 32'h12345000, 5'd7, 4'd10, C_WB | C_IMM, 1'b0);
        cyc(1'b1, "lui");
        drive(32'h4032D313, 32'h11C, 32'h5, 32'h6, 32'h5, 32'h6, 32'h403, 5'd6, 4'd7, C_WB | C_IMM, 1'b0);
        cyc(1'b1, "srai");
        drive(32'h0000007F, 32'h120, 32'h99, 32'h99, 32'h0, 32'h0, 32'h0, 5'd0, 4'd0, 7'd0, 1'b1);
        cyc(1'b1, "illegal");

        wb_wr_en = 1'b1;
        wb_addr  = 5'd1;
        wb_data  = 32'd30;
        drive(32'h001101B3, 32'h124, 32'h40, 32'h0, 32'h40, BYP_EXP, 32'h0, 5'd3, 4'd0, C_WB, 1'b0);
        cyc(1'b1, "bypass");
        wb_wr_en = 1'b0;

        ex_ready = 1'b0;
        ex_flush = 1'b1;
        drive(32'h01400093, 32'h128, 32'h0, 32'h0, 32'h0, 32'h0, 32'd20, 5'd1, 4'd0, C_WB | C_IMM, 1'b0);
        cyc(1'b0, "flush");
        ex_flush = 1'b0;
        ex_ready = 1'b1;
        if_valid = 1'b0;
        cyc(1'b1, "post_flush");

        drive(32'h0000A103, 32'h200, 32'h1000, 32'h3, 32'h1000, 32'h0, 32'h0, 5'd2, 4'd0, C_WB | C_MRD | C_IMM, 1'b0);
        cyc(1'b1, "lw2");
        ex_ready = 1'b0;
        drive(32'h001101B3, 32'h204, 32'h22, 32'h11, 32'h22, 32'h11, 32'h0, 5'd3, 4'd0, C_WB, 1'b0);
        cyc(1'b0, "stall2");
        #2;
        reset = 1'b0;
        #1;
        total++;
        assert (obs === '0 && ex_valid === 1'b0) else begin
            bad++;
            $error("FAIL mid_reset got=%h/%0b exp=0", obs, ex_valid);
        end
        if_valid = 1'b0;
        ex_ready = 1'b1;
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        drive(32'h01400093, 32'h300, 32'h0, 32'h55, 32'h0, 32'h55, 32'd20, 5'd1, 4'd0, C_WB | C_IMM, 1'b0);
        cyc(1'b1, "post_reset");
        if_valid = 1'b0;
        cyc(1'b1, "drain");
        cyc(1'b1, "idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
